pe_mac_os: RTL and testbench
============================

Name: pe_mac_os

Overview:
- Output-stationary MAC processing element for the next-generation systolic array. Replaces the global-counter-cleared PE.
- Valid-qualified operands, a per-beat last marker to close each dot product, a parametrised accumulator width, and a ready/valid result drain chain down the column.
- Tiles N×N instances; row-0 inputs come from the skew buffers, and the bottom-row drain feeds the result collector.

Parameters:
- DATAWIDTH, 16, operand width.
- ACC_WIDTH, 40, accumulator/result width; must be >= 2*DATAWIDTH.
- SIGNED, 1, 1 = two's-complement operands, 0 = unsigned.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- a_in  in  DATAWIDTH  operand A from left
- a_vld_in  in  1  A valid
- last_in  in  1  final beat of current dot product, travels with A
- b_in  in  DATAWIDTH  operand B from top
- b_vld_in  in  1  B valid
- a_out  out  DATAWIDTH  registered A to right
- a_vld_out  out  1  registered A valid
- last_out  out  1  registered last
- b_out  out  DATAWIDTH  registered B to bottom
- b_vld_out  out  1  registered B valid
- c_in  in  ACC_WIDTH  drain data from PE above
- c_vld_in  in  1  drain valid from above
- c_rdy_out  out  1  ready to PE above
- c_out  out  ACC_WIDTH  drain data to PE below
- c_vld_out  out  1  drain valid to below
- c_rdy_in  in  1  ready from below
- err_ovr  out  1  sticky: result lost

Behaviour:
- Reset: all registered outputs, acc, res_reg, flags and err_ovr go to 0. The FSM goes to IDLE. Reset mid-operation discards all partial and pending results.
- Forwarding:
  - a/b data, valids and last are registered every cycle, unconditionally. Latency is 1; there is no stall.
  - Data registers load only when the matching valid is 1. Valid/last registers always load.
- Fire: fire = a_vld_in & b_vld_in. Product is 2*DATAWIDTH, signed or unsigned per SIGNED, extended to ACC_WIDTH.
- last_in without fire is ignored, and the bench asserts it never occurs.
- FSM states:
  - IDLE: fire & ~last_in → acc = prod, go to ACC. fire & last_in → result = prod, stay in IDLE (single-beat product).
  - ACC: fire & ~last_in → acc += prod. fire & last_in → result = acc + prod, acc := 0, go to IDLE.
  - No fire: hold state.
- Result capture: completed result is written to res_reg and res_pend := 1 on the same edge.
  - If res_pend is already 1 and not being consumed this cycle, the new result is dropped, err_ovr := 1, and the old result is retained.
- Drain output slot: single register (c_out, c_vld_out).
  - Slot free = ~c_vld_out | c_rdy_in.
  - When free and res_pend: load res_reg, clear res_pend. Own result has priority.
  - Else when free and c_vld_in: load c_in.
  - Else when free: c_vld_out := 0.
  - c_rdy_out = free & ~res_pend (combinational).
  - c_out stays stable while c_vld_out & ~c_rdy_in.
- Simultaneous events:
  - res_pend consumed into the slot on the same edge a new result completes: new result is captured, no error.
  - Capture and drain-through are independent of the accumulation FSM.
- Arithmetic: wrap modulo 2^ACC_WIDTH unless PE_SATURATE_EN is defined.
- Throughput: one MAC per cycle; back-to-back dot products need no idle beat.

Optional Feature:
- Macro: PE_SATURATE_EN.
- Defined:
  - Accumulate and final add saturate to the ACC_WIDTH range: signed min/max when SIGNED=1, 0/all-ones when SIGNED=0.
  - Sticky output sat_flag (1 bit) is added and set on any clamp. It is cleared only by reset.
- Undefined: wrap-around arithmetic, and no sat_flag port.

Decomposition:
- Package pe_pkg holds:
  - the FSM enum pe_state_e {IDLE, ACC};
  - the sat_add function, parametrised by width and signedness;
  - the localparam check ACC_WIDTH >= 2*DATAWIDTH (elaboration assertion).
- Sub-module pe_drain_slot holds the one-entry ready/valid output register with a priority input. It is reused by the row-edge collector.

Test Plan:
- DATAWIDTH=16, SIGNED=1, beats (3,4),(−2,5),(7,−1) with last on beat 3, c_rdy_in=1 → c_out=−5, c_vld_out high one cycle at 2 cycles after last beat; a_out/b_out mirror inputs at 1-cycle lag.
- Back-to-back: dot1 (1,1)x2 last, then immediately dot2 (2,3) last → drained results 2 then 6, no idle gap required, err_ovr=0.
- Drain priority: hold c_rdy_in=0, complete own result 9 while c_vld_in=1 with c_in=100 → c_rdy_out=0. On release, c_out=9 then 100, with c_out stable while stalled.
- Overflow: c_rdy_in=0, complete results 5 then 8 → err_ovr=1, and after release only 5 drains.
- Saturation (PE_SATURATE_EN, ACC_WIDTH=32): 3 beats of (32767,32767) after acc preload near 0x7FFF_FFFF → c_out=0x7FFF_FFFF, sat_flag=1. Without macro, same stimulus → wrapped value, matched against the modulo-2^32 model.
- Reset mid-ACC after 2 beats, then new dot (4,4) last → c_out=16, with no residue from the aborted dot.

Source files
------------

// File: rtl/pe_pkg.sv
// Shared types and helpers for the output-stationary MAC processing element.
// Provides the accumulation FSM encoding, the width legality check and a saturating adder.
package pe_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } pe_state_e;

    // Operands of sat_add are pre-extended to this width so one function serves every ACC_WIDTH.
    localparam int unsigned SAT_MAX_W = 128;
    localparam logic [SAT_MAX_W-1:0] SAT_ONE = SAT_MAX_W'(1);

    function automatic bit acc_width_ok(input int dw, input int aw);
        return (aw >= 2 * dw) && (aw < SAT_MAX_W);
    endfunction

    // Adds two width-bit values (already sign/zero-extended to SAT_MAX_W) and clamps to the
    // representable range of a width-bit signed or unsigned number.
    function automatic logic [SAT_MAX_W-1:0] sat_add(
        input  logic [SAT_MAX_W-1:0] x,
        input  logic [SAT_MAX_W-1:0] y,
        input  int unsigned          width,
        input  bit                   is_signed,
        output logic                 clamped
    );
        logic [SAT_MAX_W-1:0] sum;
        logic [SAT_MAX_W-1:0] hi;
        sum     = x + y;
        clamped = 1'b0;
        if (is_signed) begin
            hi = (SAT_ONE << (width - 1)) - SAT_ONE;
            if ($signed(sum) > $signed(hi)) begin
                sum     = hi;
                clamped = 1'b1;
            end else if ($signed(sum) < $signed(~hi)) begin
                sum     = ~hi;
                clamped = 1'b1;
            end
        end else begin
            hi = (SAT_ONE << width) - SAT_ONE;
            if (sum > hi) begin
                sum     = hi;
                clamped = 1'b1;
            end
        end
        return sum;
    endfunction

endpackage

// File: rtl/pe_drain_slot.sv
// One-entry ready/valid output register with a priority source and a pass-through source.
// The priority source always wins when the slot can accept; also used by the row-edge collector.
module pe_drain_slot #(
    parameter int WIDTH = 40
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] pri_data,
    input  logic             pri_vld,
    output logic             pri_take,
    input  logic [WIDTH-1:0] sec_data,
    input  logic             sec_vld,
    output logic             sec_rdy,
    output logic [WIDTH-1:0] out_data,
    output logic             out_vld,
    input  logic             out_rdy
);

    logic free;

    assign free     = ~out_vld | out_rdy;
    assign pri_take = free & pri_vld;
    assign sec_rdy  = free & ~pri_vld;

    // out_data only changes when the slot is free, so it holds steady under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data <= '0;
            out_vld  <= 1'b0;
        end else if (free) begin
            if (pri_vld) begin
                out_data <= pri_data;
                out_vld  <= 1'b1;
            end else if (sec_vld) begin
                out_data <= sec_data;
                out_vld  <= 1'b1;
            end else begin
                out_vld  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/pe_mac_os.sv
// Output-stationary MAC PE: valid/last qualified operands, one pending result, drain chain.
// Define PE_SATURATE_EN for saturating accumulation and the sticky sat_flag output.
module pe_mac_os
    import pe_pkg::*;
#(
    parameter int DATAWIDTH = 16,
    parameter int ACC_WIDTH = 40,
    parameter int SIGNED    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [DATAWIDTH-1:0] a_in,
    input  logic                 a_vld_in,
    input  logic                 last_in,
    input  logic [DATAWIDTH-1:0] b_in,
    input  logic                 b_vld_in,
    output logic [DATAWIDTH-1:0] a_out,
    output logic                 a_vld_out,
    output logic                 last_out,
    output logic [DATAWIDTH-1:0] b_out,
    output logic                 b_vld_out,
    input  logic [ACC_WIDTH-1:0] c_in,
    input  logic                 c_vld_in,
    output logic                 c_rdy_out,
    output logic [ACC_WIDTH-1:0] c_out,
    output logic                 c_vld_out,
    input  logic                 c_rdy_in,
    output logic                 err_ovr
`ifdef PE_SATURATE_EN
    ,
    output logic                 sat_flag
`endif
);

    if (!acc_width_ok(DATAWIDTH, ACC_WIDTH)) begin : g_bad_width
        $error("pe_mac_os: ACC_WIDTH must be >= 2*DATAWIDTH");
    end

    localparam int PW        = 2 * DATAWIDTH;
    localparam bit IS_SIGNED = (SIGNED != 0);

    pe_state_e            state;
    logic [ACC_WIDTH-1:0] acc;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH-1:0] prod;
    logic [ACC_WIDTH-1:0] sum;
    logic [ACC_WIDTH-1:0] res_reg;
    logic [PW-1:0]        a_ext;
    logic [PW-1:0]        b_ext;
    logic [PW-1:0]        prod_raw;
    logic                 fire;
    logic                 done;
    logic                 res_pend;
    logic                 pend_take;

    assign fire = a_vld_in & b_vld_in;
    assign done = fire & last_in;

    // Extending both operands to 2*DATAWIDTH first makes the low product bits exact either way.
    assign a_ext    = IS_SIGNED ? PW'($signed(a_in)) : PW'(a_in);
    assign b_ext    = IS_SIGNED ? PW'($signed(b_in)) : PW'(b_in);
    assign prod_raw = a_ext * b_ext;
    assign prod     = IS_SIGNED ? ACC_WIDTH'($signed(prod_raw)) : ACC_WIDTH'(prod_raw);

    // Starting from zero in IDLE lets one adder serve both the first beat and the accumulate.
    assign acc_base = (state == ACC) ? acc : '0;

`ifdef PE_SATURATE_EN
    logic clamped;

    function automatic logic [SAT_MAX_W-1:0] widen(input logic [ACC_WIDTH-1:0] x);
        return IS_SIGNED ? SAT_MAX_W'($signed(x)) : SAT_MAX_W'(x);
    endfunction

    always_comb begin
        // NOTE: every variable written here gets a default first, so no path can infer a latch.
        clamped = 1'b0;
        sum     = ACC_WIDTH'(sat_add(widen(acc_base), widen(prod), ACC_WIDTH, IS_SIGNED, clamped));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_flag <= 1'b0;
        end else if (fire && clamped) begin
            sat_flag <= 1'b1;
        end
    end
`else
    assign sum = acc_base + prod;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
        end else if (fire) begin
            if (last_in) begin
                state <= IDLE;
                acc   <= '0;
            end else begin
                state <= ACC;
                acc   <= sum;
            end
        end
    end

    // A finished result is dropped only if the previous one is still waiting after this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_reg  <= '0;
            res_pend <= 1'b0;
            err_ovr  <= 1'b0;
        end else if (done) begin
            if (res_pend && !pend_take) begin
                err_ovr <= 1'b1;
            end else begin
                res_reg  <= sum;
                res_pend <= 1'b1;
            end
        end else if (pend_take) begin
            res_pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_out     <= '0;
            b_out     <= '0;
            a_vld_out <= 1'b0;
            b_vld_out <= 1'b0;
            last_out  <= 1'b0;
        end else begin
            a_vld_out <= a_vld_in;
            b_vld_out <= b_vld_in;
            last_out  <= last_in;
            if (a_vld_in) a_out <= a_in;
            if (b_vld_in) b_out <= b_in;
        end
    end

    pe_drain_slot #(
        .WIDTH(ACC_WIDTH)
    ) u_drain (
        .clk      (clk),
        .rst_n    (rst_n),
        .pri_data (res_reg),
        .pri_vld  (res_pend),
        .pri_take (pend_take),
        .sec_data (c_in),
        .sec_vld  (c_vld_in),
        .sec_rdy  (c_rdy_out),
        .out_data (c_out),
        .out_vld  (c_vld_out),
        .out_rdy  (c_rdy_in)
    );

endmodule

// File: tb/tb_pe_mac_os.sv
// Bench for pe_mac_os: a transaction-level model (dot sums, pending/slot queues) checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_pe_mac_os;

    localparam int DW = 16;
    localparam int AW = 32;
    localparam longint ACC_MAX = (longint'(1) <<< (AW - 1)) - 1;
    localparam longint ACC_MIN = -(longint'(1) <<< (AW - 1));

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] a_in, b_in, a_out, b_out;
    logic          a_vld_in, b_vld_in, last_in, a_vld_out, b_vld_out, last_out;
    logic [AW-1:0] c_in, c_out;
    logic          c_vld_in, c_rdy_out, c_vld_out, c_rdy_in, err_ovr;
`ifdef PE_SATURATE_EN
    logic          sat_flag;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pe_mac_os #(
        .DATAWIDTH(DW),
        .ACC_WIDTH(AW),
        .SIGNED   (1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .a_in     (a_in),
        .a_vld_in (a_vld_in),
        .last_in  (last_in),
        .b_in     (b_in),
        .b_vld_in (b_vld_in),
        .a_out    (a_out),
        .a_vld_out(a_vld_out),
        .last_out (last_out),
        .b_out    (b_out),
        .b_vld_out(b_vld_out),
        .c_in     (c_in),
        .c_vld_in (c_vld_in),
        .c_rdy_out(c_rdy_out),
        .c_out    (c_out),
        .c_vld_out(c_vld_out),
        .c_rdy_in (c_rdy_in),
        .err_ovr  (err_ovr)
`ifdef PE_SATURATE_EN
        ,
        .sat_flag (sat_flag)
`endif
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Brings a running sum back into the accumulator range: clamp or wrap modulo 2^AW.
    function automatic longint fit(input longint v, output bit clamp);
        clamp = 1'b0;
`ifdef PE_SATURATE_EN
        if (v > ACC_MAX) begin
            clamp = 1'b1;
            return ACC_MAX;
        end
        if (v < ACC_MIN) begin
            clamp = 1'b1;
            return ACC_MIN;
        end
        return v;
`else
        return longint'($signed(v[AW-1:0]));
`endif
    endfunction

    // ---------------- behavioural model ----------------
    longint        dot_sum;
    logic [AW-1:0] pend_q[$];
    logic [AW-1:0] slot_q[$];
    bit            m_err, m_sat;
    logic [DW-1:0] m_a, m_b;
    bit            m_av, m_bv, m_last;

    always @(posedge clk or negedge rst_n) begin
        bit     fire, free, clamp;
        longint prod, total;
        if (!rst_n) begin
            dot_sum = 0;
            pend_q.delete();
            slot_q.delete();
            m_err = 1'b0; m_sat = 1'b0;
            m_a = '0; m_b = '0; m_av = 1'b0; m_bv = 1'b0; m_last = 1'b0;
        end else begin
            fire = a_vld_in && b_vld_in;
            free = (slot_q.size() == 0) || c_rdy_in;
            if (last_in) check("last_with_fire", 64'(fire), 64'd1);
            if (free) begin
                slot_q.delete();
                if (pend_q.size() != 0) slot_q.push_back(pend_q.pop_front());
                else if (c_vld_in) slot_q.push_back(c_in);
            end
            if (fire) begin
                prod  = longint'($signed(a_in)) * longint'($signed(b_in));
                total = fit(dot_sum + prod, clamp);
                if (clamp) m_sat = 1'b1;
                if (last_in) begin
                    dot_sum = 0;
                    if (pend_q.size() != 0) m_err = 1'b1;
                    else pend_q.push_back(total[AW-1:0]);
                end else begin
                    dot_sum = total;
                end
            end
            m_av = a_vld_in; m_bv = b_vld_in; m_last = last_in;
            if (a_vld_in) m_a = a_in;
            if (b_vld_in) m_b = b_in;
        end
    end

    always @(negedge clk) begin
        check("a_vld_out", 64'(a_vld_out), 64'(m_av));
        check("b_vld_out", 64'(b_vld_out), 64'(m_bv));
        check("last_out", 64'(last_out), 64'(m_last));
        check("a_out", 64'(a_out), 64'(m_a));
        check("b_out", 64'(b_out), 64'(m_b));
        check("c_vld_out", 64'(c_vld_out), 64'(slot_q.size() != 0));
        if (slot_q.size() != 0) check("c_out", 64'(c_out), 64'(slot_q[0]));
        check("c_rdy_out", 64'(c_rdy_out),
              64'(((slot_q.size() == 0) || c_rdy_in) && (pend_q.size() == 0)));
        check("err_ovr", 64'(err_ovr), 64'(m_err));
`ifdef PE_SATURATE_EN
        check("sat_flag", 64'(sat_flag), 64'(m_sat));
`endif
    end

    // ---------------- stimulus helpers ----------------
    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic last);
        a_in = a; b_in = b; a_vld_in = 1'b1; b_vld_in = 1'b1; last_in = last;
        sync();
        a_vld_in = 1'b0; b_vld_in = 1'b0; last_in = 1'b0;
    endtask

    task automatic expect_drain(input logic [AW-1:0] exp, input string name, output int waited);
        bit seen;
        seen   = 1'b0;
        waited = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            waited++;
            if (c_vld_out && c_rdy_in) begin
                seen = 1'b1;
                check(name, 64'(c_out), 64'(exp));
            end
        end
        check({name, "_seen"}, 64'(seen), 64'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int w;
        rst_n = 1'b0;
        a_in = '0; b_in = '0; a_vld_in = 1'b0; b_vld_in = 1'b0; last_in = 1'b0;
        c_in = '0; c_vld_in = 1'b0; c_rdy_in = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_c_vld_out", 64'(c_vld_out), 64'd0);
        check("rst_a_out", 64'(a_out), 64'd0);
        check("rst_a_vld_out", 64'(a_vld_out), 64'd0);
        check("rst_err_ovr", 64'(err_ovr), 64'd0);
        rst_n = 1'b1;
        sync();

        // Dot product 3*4 + (-2)*5 + 7*(-1) = -5, with an A-only beat in between.
        drive_beat(16'd3, 16'd4, 1'b0);
        check("fwd_a_out", 64'(a_out), 64'd3);
        check("fwd_b_out", 64'(b_out), 64'd4);
        a_in = 16'h1234; a_vld_in = 1'b1; b_in = 16'hDEAD;
        sync();
        a_vld_in = 1'b0;
        check("fwd_a_only", 64'(a_out), 64'h1234);
        check("fwd_b_held", 64'(b_out), 64'd4);
        drive_beat(-16'sd2, 16'd5, 1'b0);
        drive_beat(16'd7, -16'sd1, 1'b1);
        @(negedge clk);
        check("dot1_lat1_vld", 64'(c_vld_out), 64'd0);
        @(negedge clk);
        check("dot1_lat2_vld", 64'(c_vld_out), 64'd1);
        check("dot1_result", 64'(c_out), 64'hFFFF_FFFB);
        @(negedge clk);
        check("dot1_one_cycle", 64'(c_vld_out), 64'd0);
        sync();

        // Back-to-back: (1,1)x2 -> 2, then immediately (2,3) -> 6.
        drive_beat(16'd1, 16'd1, 1'b0);
        drive_beat(16'd1, 16'd1, 1'b1);
        drive_beat(16'd2, 16'd3, 1'b1);
        expect_drain(32'd2, "b2b_first", w);
        expect_drain(32'd6, "b2b_second", w);
        check("b2b_no_gap", 64'(w), 64'd1);
        check("b2b_err_ovr", 64'(err_ovr), 64'd0);
        sync();

        // Own result 9 beats an upstream 100 while the slot is stalled.
        c_rdy_in = 1'b0;
        drive_beat(16'd3, 16'd3, 1'b1);
        c_in = 32'd100; c_vld_in = 1'b1;
        check("prio_rdy_low", 64'(c_rdy_out), 64'd0);
        sync();
        repeat (3) begin
            @(negedge clk);
            check("prio_stall_out", 64'(c_out), 64'd9);
            check("prio_stall_vld", 64'(c_vld_out), 64'd1);
            check("prio_stall_rdy", 64'(c_rdy_out), 64'd0);
        end
        sync();
        c_rdy_in = 1'b1;
        expect_drain(32'd9, "prio_own", w);
        sync();
        c_vld_in = 1'b0;
        expect_drain(32'd100, "prio_upstream", w);
        sync();

        // Overflow: slot holds 77, result 5 pends, result 8 is lost.
        c_rdy_in = 1'b0; c_in = 32'd77; c_vld_in = 1'b1;
        sync();
        c_vld_in = 1'b0;
        drive_beat(16'd5, 16'd1, 1'b1);
        drive_beat(16'd2, 16'd4, 1'b1);
        check("ovr_err", 64'(err_ovr), 64'd1);
        c_rdy_in = 1'b1;
        expect_drain(32'd77, "ovr_upstream", w);
        expect_drain(32'd5, "ovr_kept", w);
        repeat (3) begin
            @(negedge clk);
            check("ovr_no_more", 64'(c_vld_out), 64'd0);
        end
        sync();

        // Five beats of 32767^2 = 0x3FFF0001 overrun a 32-bit signed accumulator.
        repeat (4) drive_beat(16'd32767, 16'd32767, 1'b0);
        drive_beat(16'd32767, 16'd32767, 1'b1);
`ifdef PE_SATURATE_EN
        expect_drain(32'h7FFF_FFFF, "sat_result", w);
        check("sat_flag_set", 64'(sat_flag), 64'd1);
`else
        expect_drain(32'h3FFB_0005, "wrap_result", w);
`endif
        sync();

        // Reset in the middle of a dot product leaves no residue.
        drive_beat(16'd10, 16'd10, 1'b0);
        drive_beat(16'd20, 16'd20, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_err", 64'(err_ovr), 64'd0);
        check("rst_mid_vld", 64'(c_vld_out), 64'd0);
        check("rst_mid_a_out", 64'(a_out), 64'd0);
`ifdef PE_SATURATE_EN
        check("rst_mid_sat", 64'(sat_flag), 64'd0);
`endif
        sync();
        rst_n = 1'b1;
        sync();
        drive_beat(16'd4, 16'd4, 1'b1);
        expect_drain(32'd16, "post_rst_result", w);

        repeat (3) sync();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
